// File: rtl/glitch_sequencer.sv
// Trigger-to-glitch sequencer: latches a glitch configuration on arm, then times delay/width/gap after a trigger edge.
// Optional repeated glitches are built when the macro GLITCH_REPEAT_EN is defined.
module glitch_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             arm,
    input  logic             abort,
    input  logic             trigger,
    input  logic [7:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_gap,
    input  logic [7:0]       cfg_repeat,
    output logic             en,
    output logic [7:0]       mode,
    output logic             armed,
    output logic             busy,
    output logic             done
);

    // state    | meaning
    // S_IDLE   | waiting for arm
    // S_ARMED  | config latched, waiting for trigger rising edge
    // S_DELAY  | counting trigger-to-glitch delay
    // S_GLITCH | en asserted for the glitch width
    // S_GAP    | en low between repeated glitches (repeat build only)
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
`ifdef GLITCH_REPEAT_EN
        S_GAP,
`endif
        S_GLITCH
    } state_t;

    state_t           state;
    logic             trig_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lat_delay;
    logic [CNT_W-1:0] lat_width;
    logic [CNT_W-1:0] w_load;
    logic             trig_edge;

`ifdef GLITCH_REPEAT_EN
    logic [CNT_W-1:0] lat_gap;
    logic [7:0]       lat_repeat;
    logic [7:0]       rep_cnt;
    logic [CNT_W-1:0] g_load;

    assign g_load = (lat_gap == '0) ? '0 : lat_gap - CNT_W'(1);
`else
    logic unused_cfg;

    assign unused_cfg = ^{cfg_gap, cfg_repeat};
`endif

    // Counters hold "cycles remaining after this one", so a zero width still yields one cycle.
    assign w_load    = (lat_width == '0) ? '0 : lat_width - CNT_W'(1);
    assign trig_edge = trigger & ~trig_q;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= S_IDLE;
            trig_q    <= 1'b1;
            cnt       <= '0;
            lat_delay <= '0;
            lat_width <= '0;
            en        <= 1'b0;
            mode      <= 8'h00;
            armed     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef GLITCH_REPEAT_EN
            lat_gap    <= '0;
            lat_repeat <= 8'h00;
            rep_cnt    <= 8'h00;
`endif
        end else begin
            trig_q <= trigger;
            done   <= 1'b0;
            if (abort) begin
                state <= S_IDLE;
                cnt   <= '0;
                en    <= 1'b0;
                armed <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (arm) begin
                            lat_delay <= cfg_delay;
                            lat_width <= cfg_width;
                            mode      <= cfg_mode;
`ifdef GLITCH_REPEAT_EN
                            lat_gap    <= cfg_gap;
                            lat_repeat <= cfg_repeat;
`endif
                            state     <= S_ARMED;
                            armed     <= 1'b1;
                        end
                    end
                    S_ARMED: begin
                        if (trig_edge) begin
                            armed <= 1'b0;
                            busy  <= 1'b1;
`ifdef GLITCH_REPEAT_EN
                            rep_cnt <= lat_repeat;
`endif
                            if (lat_delay == '0) begin
                                state <= S_GLITCH;
                                en    <= 1'b1;
                                cnt   <= w_load;
                            end else begin
                                state <= S_DELAY;
                                cnt   <= lat_delay - CNT_W'(1);
                            end
                        end
                    end
                    S_DELAY: begin
                        if (cnt == '0) begin
                            state <= S_GLITCH;
                            en    <= 1'b1;
                            cnt   <= w_load;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    S_GLITCH: begin
                        if (cnt == '0) begin
`ifdef GLITCH_REPEAT_EN
                            if (rep_cnt != 8'h00) begin
                                state   <= S_GAP;
                                en      <= 1'b0;
                                cnt     <= g_load;
                                rep_cnt <= rep_cnt - 8'd1;
                            end else begin
`else
                            begin
`endif
                                state <= S_IDLE;
                                en    <= 1'b0;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
`ifdef GLITCH_REPEAT_EN
                    S_GAP: begin
                        if (cnt == '0) begin
                            state <= S_GLITCH;
                            en    <= 1'b1;
                            cnt   <= w_load;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
`endif
                    default: begin
                        state <= S_IDLE;
                        en    <= 1'b0;
                        armed <= 1'b0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_glitch_sequencer.sv
// Scoreboard bench for glitch_sequencer: expected en/done cycles come from a pulse-train model of delay/width/gap/repeat.
module tb_glitch_sequencer;
    localparam int CNT_W = 8;
`ifdef GLITCH_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic             clk_in = 1'b0;
    logic             rst, arm, abort, trigger;
    logic [7:0]       cfg_mode, cfg_repeat;
    logic [CNT_W-1:0] cfg_delay, cfg_width, cfg_gap;
    logic             en, armed, busy, done;
    logic [7:0]       mode;

    glitch_sequencer #(.CNT_W(CNT_W)) dut (
        .clk_in(clk_in), .rst(rst), .arm(arm), .abort(abort), .trigger(trigger),
        .cfg_mode(cfg_mode), .cfg_delay(cfg_delay), .cfg_width(cfg_width),
        .cfg_gap(cfg_gap), .cfg_repeat(cfg_repeat),
        .en(en), .mode(mode), .armed(armed), .busy(busy), .done(done)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int         cyc;
        bit         is_done;
        logic [7:0] mode;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, req, cyc);
        end
    endtask

    task automatic check_out(input bit is_d);
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_%s: output seen at cycle %0d, required none", is_d ? "done" : "en", cyc);
        end else begin
            e = sb.pop_front();
            if (e.cyc != cyc || e.is_done != is_d || mode !== e.mode) begin
                n_err++;
                $display("FAIL sb_%s: got cycle %0d mode %h, required cycle %0d %s mode %h",
                         is_d ? "done" : "en", cyc, mode, e.cyc, e.is_done ? "done" : "en", e.mode);
            end
        end
    endtask

    // Monitor: owns the cycle count and checks every en/done the DUT presents.
    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            cyc++;
            if (en === 1'b1)   check_out(1'b0);
            if (done === 1'b1) check_out(1'b1);
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    // Pulse-train model: edge sampled in cycle t gives pulses of max(w,1) separated by max(g,1).
    task automatic model_push(input int t, input int d, input int w, input int g, input int r,
                              input logic [7:0] m, output int dc);
        int   wr, gr, np, s, last;
        exp_t e;
        wr = (w == 0) ? 1 : w;
        gr = (g == 0) ? 1 : g;
        np = REP ? r + 1 : 1;
        s  = t + 1 + d;
        last = s;
        for (int p = 0; p < np; p++) begin
            for (int i = 0; i < wr; i++) begin
                e.cyc = s + i; e.is_done = 1'b0; e.mode = m;
                sb.push_back(e);
            end
            last = s + wr - 1;
            s    = s + wr + gr;
        end
        e.cyc = last + 1; e.is_done = 1'b1; e.mode = m;
        sb.push_back(e);
        dc = last + 1;
    endtask

    task automatic load_cfg(input int d, input int w, input int g, input int r, input logic [7:0] m);
        cfg_delay  = CNT_W'(d);
        cfg_width  = CNT_W'(w);
        cfg_gap    = CNT_W'(g);
        cfg_repeat = 8'(r);
        cfg_mode   = m;
    endtask

    task automatic run_seq(input int d, input int w, input int g, input int r,
                           input logic [7:0] m, input int pre, input bit noise);
        int t, dc;
        load_cfg(d, w, g, r, m);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("armed_after_arm", armed, 1);
        chk("mode_latched", mode, m);
        load_cfg($urandom, $urandom, $urandom, $urandom, 8'($urandom));
        trigger = 1'b0;
        repeat (pre) tick();
        chk("armed_waiting", armed, 1);
        trigger = 1'b1;
        t = cyc;
        model_push(t, d, w, g, r, m, dc);
        tick();
        chk("busy_after_edge", busy, 1);
        for (int k = 0; k < 20000 && cyc < dc + 2; k++) begin
            if (noise) begin
                trigger = 1'($urandom);
                arm     = (cyc < dc) && ($urandom_range(0, 5) == 0);
            end
            tick();
            if (cyc == dc) begin
                chk("idle_at_done_busy", busy, 0);
                chk("idle_at_done_armed", armed, 0);
            end
        end
        arm = 1'b0;
        trigger = 1'b0;
        tick();
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, dc;
        rst = 1'b1; arm = 1'b1; abort = 1'b0; trigger = 1'b0;
        load_cfg(7, 7, 7, 7, 8'hA5);
        repeat (3) tick();
        chk("rst_en", en, 0);
        chk("rst_mode", mode, 0);
        chk("rst_armed", armed, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0; arm = 1'b0;
        tick();

        run_seq(5, 3, 0, 0, 8'h08, 2, 1'b0);
        run_seq(0, 0, 0, 0, 8'h3C, 1, 1'b0);
        run_seq(2, 2, 3, 2, 8'h11, 1, 1'b0);
        run_seq(255, 1, 0, 0, 8'hE1, 1, 1'b0);
        run_seq(0, 255, 0, 0, 8'h7E, 1, 1'b0);
        run_seq(1, 1, 255, 1, 8'h42, 3, 1'b0);

        // Abort has priority over arm in IDLE.
        abort = 1'b1; arm = 1'b1;
        tick();
        abort = 1'b0; arm = 1'b0;
        chk("abort_beats_arm", armed, 0);

        // Abort in the second glitch cycle.
        load_cfg(1, 5, 0, 0, 8'h5A);
        arm = 1'b1;
        tick();
        arm = 1'b0; trigger = 1'b0;
        tick();
        trigger = 1'b1;
        t = cyc;
        model_push(t, 1, 2, 0, 0, 8'h5A, dc);
        void'(sb.pop_back());
        tick();
        trigger = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_en", en, 0);
        chk("abort_armed", armed, 0);
        chk("abort_busy", busy, 0);
        repeat (12) tick();
        chk("abort_sb_drained", sb.size(), 0);

        // Trigger held high through reset and arm is not an edge.
        trigger = 1'b1; rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        load_cfg(3, 2, 0, 0, 8'h99);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat (4) tick();
        chk("held_trig_armed", armed, 1);
        chk("held_trig_busy", busy, 0);
        trigger = 1'b0;
        tick();
        trigger = 1'b1;
        t = cyc;
        model_push(t, 3, 2, 0, 0, 8'h99, dc);
        for (int k = 0; k < 100 && cyc < dc + 2; k++) tick();
        trigger = 1'b0;
        tick();
        chk("held_trig_sb_drained", sb.size(), 0);

        // Reset during DELAY.
        load_cfg(10, 10, 0, 0, 8'hC3);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_en", en, 0);
        chk("rst_mid_mode", mode, 0);
        chk("rst_mid_armed", armed, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        repeat (30) tick();

        for (int i = 0; i < 25; i++) begin
            run_seq($urandom_range(0, 20), $urandom_range(0, 6), $urandom_range(0, 4),
                    $urandom_range(0, 3), 8'($urandom), $urandom_range(1, 4), 1'b1);
        end

        chk("final_sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
